fpga_cfg_loader: RTL and testbench

//  Wishbone slave that loads the FPGA fabric configuration chain. Firmware writes bit length and
//  32-bit bitstream words; block buffers them in a FIFO, serialises LSB-first onto the chain,

---
 rtl/fpga_cfg_loader_pkg.sv | 32 +++
 rtl/fpga_cfg_loader_if.sv | 24 ++
 rtl/fpga_cfg_fifo.sv | 57 +++++
 rtl/fpga_cfg_loader.sv | 181 ++++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpga_cfg_loader_pkg.sv
// Shared register map, status bit positions and FSM encoding
// for the FPGA configuration-chain loader.
package fpga_cfg_loader_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_LEN  = 2'd1;
  localparam logic [1:0] REG_DATA = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;

  localparam int ST_BUSY  = 0;
  localparam int ST_DONE  = 1;
  localparam int ST_EMPTY = 2;
  localparam int ST_FULL  = 3;
  localparam int ST_ERR   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_LATCH
  } state_e;

  function automatic logic [15:0] sat16(
    input logic [31:0] v
  );
    return (v > 32'h0000_FFFF) ? 16'hFFFF : v[15:0];
  endfunction

endpackage

// File: rtl/fpga_cfg_loader_if.sv
// Wishbone slave bus bundle between Caravel and the loader.
// Signal names keep the slave-side _i/_o suffixes.
interface fpga_cfg_loader_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_data_i;
  logic [31:0] wbs_addr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_data_o;

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i,
    output wbs_sel_i, wbs_data_i, wbs_addr_i,
    input  wbs_ack_o, wbs_data_o
  );

  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i,
    input  wbs_sel_i, wbs_data_i, wbs_addr_i,
    output wbs_ack_o, wbs_data_o
  );
endinterface

// File: rtl/fpga_cfg_fifo.sv
// Small synchronous FIFO buffering bitstream words.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module fpga_cfg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, rp_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign data_o  = mem_q[rp_q];

  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (flush_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= data_i;
        wp_q        <= wp_q + 1'b1;
      end
      if (do_pop)
        rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Wishbone slave that streams buffered bitstream words
// LSB-first into the fabric config chain, then latches it.
module fpga_cfg_loader
  import fpga_cfg_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LEN_W      = 20
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  fpga_cfg_loader_if.slave   wbs,
  output logic               cfg_data_o,
  output logic               cfg_en_o,
  output logic               cfg_latch_o,
  output logic               cfg_busy_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [31:0]       sreg_q, sreg_d;
  logic [4:0]        bcnt_q, bcnt_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ack_q;
  logic [31:0]       dat_q, rdata;

  logic [31:0]       fifo_q;
  logic              fifo_full, fifo_empty;
  logic              fifo_pop, fifo_flush;
  logic [LW-1:0]     fifo_lvl;

  logic              hit, req, acc, wr;
  logic              is_data_wr, can_push, push;
  logic              start, abort, len_wr;
  logic [1:0]        rsel;
  logic              unused_ok;

  assign rsel = wbs.wbs_addr_i[3:2];
  assign hit  = (wbs.wbs_addr_i[31:4] == BASE_ADDR[31:4]);
  assign req  = wbs.wbs_stb_i & wbs.wbs_cyc_i & hit & ~ack_q;

  // A DATA write into a full FIFO waits until the FSM pops.
  assign is_data_wr = req & wbs.wbs_we_i & (rsel == REG_DATA);
  assign can_push   = (fifo_lvl != LW'(FIFO_DEPTH)) | fifo_pop;
  assign push       = is_data_wr & can_push;
  assign acc        = req & (~is_data_wr | can_push);
  assign wr         = acc & wbs.wbs_we_i;

  assign abort  = wr & (rsel == REG_CTRL) & wbs.wbs_sel_i[0]
                & wbs.wbs_data_i[CTRL_ABORT];
  assign start  = wr & (rsel == REG_CTRL) & wbs.wbs_sel_i[0]
                & wbs.wbs_data_i[CTRL_START] & ~abort;
  assign len_wr = wr & (rsel == REG_LEN) & (state_q == S_IDLE);

  assign unused_ok = ^{wbs.wbs_addr_i[1:0], wbs.wbs_sel_i[3]};

  fpga_cfg_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (push),
    .data_i  (wbs.wbs_data_i),
    .pop_i   (fifo_pop),
    .flush_i (fifo_flush),
    .data_o  (fifo_q),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_lvl)
  );

  always_comb begin
    len_d = len_q;
    if (len_wr)
      for (int b = 0; b < LEN_W; b++)
        if (wbs.wbs_sel_i[b/8])
          len_d[b] = wbs.wbs_data_i[b];
  end

  always_comb begin
    case (rsel)
      REG_LEN:  rdata = 32'(len_q);
      REG_STAT: rdata = {sat16(32'(rem_q)), 11'd0,
                         err_q, fifo_full, fifo_empty,
                         done_q, cfg_busy_o};
      default:  rdata = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    sreg_d     = sreg_q;
    bcnt_d     = bcnt_q;
    done_d     = done_q;
    err_d      = err_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_q == '0) begin
            err_d = 1'b1;
          end else begin
            state_d = S_LOAD;
            rem_d   = len_q;
            done_d  = 1'b0;
            err_d   = 1'b0;
          end
        end
      end
      S_LOAD: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          sreg_d   = fifo_q;
          bcnt_d   = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sreg_d = sreg_q >> 1;
        rem_d  = rem_q - LEN_W'(1);
        bcnt_d = bcnt_q + 5'd1;
        if (rem_q == LEN_W'(1))
          state_d = S_LATCH;
        else if (bcnt_q == 5'd31)
          state_d = S_LOAD;
      end
      S_LATCH: begin
        state_d    = S_IDLE;
        done_d     = 1'b1;
        fifo_flush = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d    = S_IDLE;
      done_d     = 1'b0;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      rem_q   <= '0;
      sreg_q  <= '0;
      bcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      sreg_q  <= sreg_d;
      bcnt_q  <= bcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ack_q   <= acc;
      dat_q   <= (acc & ~wbs.wbs_we_i) ? rdata : '0;
    end
  end

  assign wbs.wbs_ack_o  = ack_q;
  assign wbs.wbs_data_o = dat_q;

  assign cfg_en_o    = (state_q == S_SHIFT);
  assign cfg_data_o  = cfg_en_o & sreg_q[0];
  assign cfg_latch_o = (state_q == S_LATCH);
  assign cfg_busy_o  = (state_q != S_IDLE);

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Directed bench for fpga_cfg_loader: bus access, serial
// stream capture and latch counting against hand-computed values.
module tb_fpga_cfg_loader;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [31:0] A_CTRL = BASE + 32'h0;
  localparam logic [31:0] A_LEN  = BASE + 32'h4;
  localparam logic [31:0] A_DATA = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cfg_data, cfg_en, cfg_latch, cfg_busy;

  fpga_cfg_loader_if bus();

  fpga_cfg_loader #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4),
    .LEN_W      (20)
  ) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wbs         (bus),
    .cfg_data_o  (cfg_data),
    .cfg_en_o    (cfg_en),
    .cfg_latch_o (cfg_latch),
    .cfg_busy_o  (cfg_busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_en  = 0;
  int n_lat = 0;
  logic [255:0] cap;

  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_en) begin
        if (n_en < 256) cap[n_en] = cfg_data;
        n_en++;
      end
      if (cfg_latch) n_lat++;
    end
  end

  task automatic chk(input string tag,
                     input logic [159:0] got,
                     input logic [159:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    cap   = '0;
    n_en  = 0;
    n_lat = 0;
  endtask

  task automatic wb(input logic [31:0] a, input logic we,
                    input logic [31:0] d, input logic [3:0] s,
                    input int tmo,
                    output logic [31:0] rd, output logic ok);
    ok = 1'b0;
    rd = '0;
    @(posedge clk); #1;
    bus.wbs_addr_i = a;
    bus.wbs_we_i   = we;
    bus.wbs_data_i = d;
    bus.wbs_sel_i  = s;
    bus.wbs_stb_i  = 1'b1;
    bus.wbs_cyc_i  = 1'b1;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (bus.wbs_ack_o) begin
        ok = 1'b1;
        rd = bus.wbs_data_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus.wbs_stb_i = 1'b0;
    bus.wbs_cyc_i = 1'b0;
    bus.wbs_we_i  = 1'b0;
  endtask

  task automatic wr(input string tag, input logic [31:0] a,
                    input logic [31:0] d);
    logic [31:0] rd;
    logic ok;
    wb(a, 1'b1, d, 4'hF, 20, rd, ok);
    if (!ok) chk({tag, "_ack"}, ok, 1'b1);
  endtask

  task automatic rdr(input string tag, input logic [31:0] a,
                     output logic [31:0] d);
    logic ok;
    wb(a, 1'b0, 32'h0, 4'hF, 20, d, ok);
    if (!ok) chk({tag, "_ack"}, ok, 1'b1);
  endtask

  task automatic wait_idle(input string tag, input int tmo);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (!cfg_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_idle"}, ok, 1'b1);
  endtask

  task automatic wait_en(input string tag, input int n,
                         input int tmo);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < tmo; i++) begin
      @(negedge clk);
      if (n_en >= n) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_en_to"}, ok, 1'b1);
  endtask

  logic [31:0] r;
  logic        ok;
  logic [31:0] w [5];
  int          k;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.wbs_stb_i  = 1'b0;
    bus.wbs_cyc_i  = 1'b0;
    bus.wbs_we_i   = 1'b0;
    bus.wbs_sel_i  = 4'h0;
    bus.wbs_data_i = '0;
    bus.wbs_addr_i = '0;
    w[0] = 32'h1111_1111;
    w[1] = 32'h2222_2222;
    w[2] = 32'h3333_3333;
    w[3] = 32'h4444_4444;
    w[4] = 32'h5555_5555;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_outs", {cfg_data, cfg_en, cfg_latch, cfg_busy,
                     bus.wbs_ack_o}, 5'b0);
    chk("rst_rdata", bus.wbs_data_o, 32'h0);
    rst = 1'b0;
    rdr("rst_stat", A_STAT, r);
    chk("rst_stat", r, 32'h0000_0004);

    // 40 bits across two words
    wr("t1", A_LEN, 32'd40);
    wr("t1", A_DATA, 32'hDEAD_BEEF);
    wr("t1", A_DATA, 32'h0000_00A5);
    clr();
    wr("t1", A_CTRL, 32'h1);
    wait_idle("t1", 200);
    chk("t1_en", n_en, 40);
    chk("t1_bits", cap[39:0], 40'hA5_DEAD_BEEF);
    chk("t1_latch", n_lat, 1);
    rdr("t1", A_STAT, r);
    chk("t1_stat", r, 32'h0000_0006);

    // FIFO full stalls the fifth word until the FSM pops
    clr();
    wr("t2", A_LEN, 32'd160);
    for (int i = 0; i < 4; i++) wr("t2", A_DATA, w[i]);
    wb(A_DATA, 1'b1, w[4], 4'hF, 15, r, ok);
    chk("t2_stall", ok, 1'b0);
    rdr("t2", A_STAT, r);
    chk("t2_stat_full", r, 32'h0000_000A);
    wr("t2", A_CTRL, 32'h1);
    wb(A_DATA, 1'b1, w[4], 4'hF, 20, r, ok);
    chk("t2_retry_ack", ok, 1'b1);
    wait_idle("t2", 400);
    chk("t2_en", n_en, 160);
    chk("t2_bits", cap[159:0], {w[4], w[3], w[2], w[1], w[0]});
    chk("t2_latch", n_lat, 1);

    // underrun: chain pauses in LOAD until the next word
    clr();
    wr("t3", A_LEN, 32'd64);
    wr("t3", A_DATA, 32'h1234_5678);
    wr("t3", A_CTRL, 32'h1);
    wait_en("t3", 32, 100);
    repeat (8) @(negedge clk);
    chk("t3_en_hold", n_en, 32);
    chk("t3_busy", cfg_busy, 1'b1);
    rdr("t3", A_STAT, r);
    chk("t3_stat", r, 32'h0020_0005);
    chk("t3_nolatch", n_lat, 0);
    wr("t3", A_DATA, 32'h9ABC_DEF0);
    wait_idle("t3", 100);
    chk("t3_en", n_en, 64);
    chk("t3_bits", cap[63:0], 64'h9ABC_DEF0_1234_5678);
    chk("t3_latch", n_lat, 1);

    // abort mid-word
    clr();
    wr("t4", A_LEN, 32'd100);
    wr("t4", A_DATA, 32'hAAAA_AAAA);
    wr("t4", A_DATA, 32'h5555_5555);
    wr("t4", A_CTRL, 32'h1);
    wait_en("t4", 10, 100);
    wr("t4", A_CTRL, 32'h3);
    chk("t4_busy", cfg_busy, 1'b0);
    k = n_en;
    repeat (5) @(negedge clk);
    chk("t4_en_stop", n_en, k);
    chk("t4_latch", n_lat, 0);
    rdr("t4", A_STAT, r);
    chk("t4_stat", r[15:0], 16'h0004);

    // zero length flags err; next valid start clears it
    clr();
    wr("t5", A_LEN, 32'd0);
    wr("t5", A_CTRL, 32'h1);
    rdr("t5", A_STAT, r);
    chk("t5_err", r[15:0], 16'h0014);
    repeat (5) @(negedge clk);
    chk("t5_no_en", n_en, 0);
    chk("t5_idle", cfg_busy, 1'b0);
    wr("t5", A_LEN, 32'd8);
    wr("t5", A_DATA, 32'h0000_00C3);
    wr("t5", A_CTRL, 32'h1);
    wait_idle("t5", 50);
    rdr("t5", A_STAT, r);
    chk("t5_stat", r[15:0], 16'h0006);
    chk("t5_en", n_en, 8);
    chk("t5_bits", cap[7:0], 8'hC3);
    chk("t5_latch", n_lat, 1);

    // address miss, byte lanes, read-zero registers
    wb(BASE + 32'h10, 1'b1, 32'h1, 4'hF, 10, r, ok);
    chk("t6_miss_ack", ok, 1'b0);
    chk("t6_miss_busy", cfg_busy, 1'b0);
    rdr("t6", A_LEN, r);
    chk("t6_len", r, 32'd8);
    wb(A_LEN, 1'b1, 32'hFFFF_FFFF, 4'b0001, 20, r, ok);
    rdr("t6", A_LEN, r);
    chk("t6_len_sel", r, 32'h0000_00FF);
    rdr("t6", A_CTRL, r);
    chk("t6_ctrl_rd", r, 32'h0);

    // async reset mid-shift
    clr();
    wr("t7", A_LEN, 32'd40);
    wr("t7", A_DATA, 32'hFFFF_FFFF);
    wr("t7", A_DATA, 32'hFFFF_FFFF);
    wr("t7", A_CTRL, 32'h1);
    wait_en("t7", 5, 50);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("t7_rst_outs", {cfg_data, cfg_en, cfg_latch, cfg_busy},
        4'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("t7_nolatch", n_lat, 0);
    rdr("t7", A_STAT, r);
    chk("t7_stat", r, 32'h0000_0004);
    rdr("t7", A_LEN, r);
    chk("t7_len", r, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
